// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_sequencer
// Purpose  : Upstream control FSM for the register-file datapath. Latches a
//            9-bit instruction (III XXX YYY) from din when idle and steps
//            through T1..T3. It drives the register-write decoder, the bus
//            source select, the A/G load enables, the ALU op and a done pulse.
// Ports    : clk      - system clock, rising edge
//            resetn   - asynchronous active-low reset
//            run      - start request, sampled only in IDLE
//            din[8:0] - instruction word in IDLE, immediate data in mvi T1
//            xxx/yyy  - IR[5:3] / IR[2:0] to the decoder
//            en, fn_sig, sn_sig - decoder enable / first / second select
//            bus_sel  - 0-7 register, 8 DIN, 9 G, 15 none
//            ain, gin, add_sub  - A load, G load, ALU op (1 = sub)
//            done     - one-cycle pulse on the last cycle of an instruction
//            busy     - high whenever the FSM is not in IDLE
//            trap     - (CTRL_SEQ_ILLEGAL_TRAP_EN only) parked on illegal op
// Config   : CTRL_SEQ_ILLEGAL_TRAP_EN - when defined, an illegal opcode parks
//            the FSM in TRAP until reset instead of completing as a NOP.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_sequencer #(
    parameter logic [8:0] IR_RESET = 9'h000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       run,
    input  logic [8:0] din,
    output logic [2:0] xxx,
    output logic [2:0] yyy,
    output logic       en,
    output logic       fn_sig,
    output logic       sn_sig,
    output logic [3:0] bus_sel,
    output logic       ain,
    output logic       gin,
    output logic       add_sub,
    output logic       done,
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
    output logic       busy,
    output logic       trap
`else
    output logic       busy
`endif
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_T1   = 3'd1;
    localparam logic [2:0] c_ST_T2   = 3'd2;
    localparam logic [2:0] c_ST_T3   = 3'd3;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
    localparam logic [2:0] c_ST_TRAP = 3'd4;
`endif

    localparam logic [2:0] c_OP_MV   = 3'b000;
    localparam logic [2:0] c_OP_MVI  = 3'b001;
    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_SUB  = 3'b011;
    localparam logic [2:0] c_OP_MVR  = 3'b100;

    localparam logic [3:0] c_BUS_DIN  = 4'd8;
    localparam logic [3:0] c_BUS_G    = 4'd9;
    localparam logic [3:0] c_BUS_NONE = 4'd15;

    logic [2:0] state_q, state_d;
    logic [8:0] ir_q,    ir_d;
    logic [2:0] w_op;

    assign w_op = ir_q[8:6];
    assign xxx  = ir_q[5:3];
    assign yyy  = ir_q[2:0];

    // ------------------------------------------------------------------
    // State and instruction registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= c_ST_IDLE;
            ir_q    <= IR_RESET;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. IR is loaded only on the IDLE->T1 transition, so
    // din may change freely while an instruction is in flight.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = c_ST_IDLE;
        ir_d    = ir_q;
        case (state_q)
            c_ST_IDLE: begin
                if (run) begin
                    ir_d    = din;
                    state_d = c_ST_T1;
                end else begin
                    state_d = c_ST_IDLE;
                end
            end
            c_ST_T1: begin
                case (w_op)
                    c_OP_ADD, c_OP_SUB:          state_d = c_ST_T2;
                    c_OP_MV, c_OP_MVI, c_OP_MVR: state_d = c_ST_IDLE;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
                    default:                     state_d = c_ST_TRAP;
`else
                    default:                     state_d = c_ST_IDLE;
`endif
                endcase
            end
            c_ST_T2: state_d = c_ST_T3;
            c_ST_T3: state_d = c_ST_IDLE;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
            // Only resetn leaves TRAP.
            c_ST_TRAP: state_d = c_ST_TRAP;
`endif
            // Unreachable encodings fall back to IDLE.
            default: state_d = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs. An Rx write is en+sn_sig, an Ry write is fn_sig alone,
    // so fn_sig and sn_sig are never asserted together.
    // ------------------------------------------------------------------
    always_comb begin
        en      = 1'b0;
        fn_sig  = 1'b0;
        sn_sig  = 1'b0;
        bus_sel = c_BUS_NONE;
        ain     = 1'b0;
        gin     = 1'b0;
        add_sub = 1'b0;
        done    = 1'b0;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
        trap    = 1'b0;
`endif
        case (state_q)
            c_ST_T1: begin
                case (w_op)
                    c_OP_MV: begin
                        bus_sel = {1'b0, ir_q[2:0]};
                        en      = 1'b1;
                        sn_sig  = 1'b1;
                        done    = 1'b1;
                    end
                    c_OP_MVI: begin
                        bus_sel = c_BUS_DIN;
                        en      = 1'b1;
                        sn_sig  = 1'b1;
                        done    = 1'b1;
                    end
                    c_OP_ADD, c_OP_SUB: begin
                        bus_sel = {1'b0, ir_q[5:3]};
                        ain     = 1'b1;
                    end
                    c_OP_MVR: begin
                        bus_sel = {1'b0, ir_q[5:3]};
                        fn_sig  = 1'b1;
                        done    = 1'b1;
                    end
                    default: begin
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
                        done = 1'b0;
`else
                        // Illegal opcode completes as a NOP.
                        done = 1'b1;
`endif
                    end
                endcase
            end
            c_ST_T2: begin
                bus_sel = {1'b0, ir_q[2:0]};
                gin     = 1'b1;
                add_sub = ir_q[6];
            end
            c_ST_T3: begin
                bus_sel = c_BUS_G;
                en      = 1'b1;
                sn_sig  = 1'b1;
                done    = 1'b1;
            end
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
            c_ST_TRAP: trap = 1'b1;
`endif
            default: begin
                bus_sel = c_BUS_NONE;
            end
        endcase
    end

    assign busy = (state_q != c_ST_IDLE);

endmodule
`default_nettype wire
